// File: rtl/jogo_memoria_pkg.sv
// jogo_memoria_pkg: shared state codes, round limit and output bundle for the memory game controller
package jogo_memoria_pkg;

    localparam int NUM_RODADAS   = 16;
    localparam int ULTIMA_RODADA = NUM_RODADAS - 1;

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        MOSTRA         = 4'h2,
        PROXIMO_MOSTRA = 4'h3,
        INICIA_RODADA  = 4'h4,
        ESPERA_JOGADA  = 4'h5,
        REGISTRA       = 4'h6,
        COMPARA        = 4'h7,
        PROXIMA_JOGADA = 4'h8,
        PROXIMA_RODADA = 4'h9,
        FIM_ACERTOU    = 4'hA,
        FIM_ERROU      = 4'hB,
        FIM_TIMEOUT    = 4'hC
    } estado_t;

    typedef struct packed {
        logic zera_e;
        logic conta_e;
        logic zera_r;
        logic conta_r;
        logic registra_r;
        logic zera_t;
        logic conta_t;
        logic mostra_leds;
        logic pronto;
        logic ganhou;
        logic perdeu;
    } saidas_t;

    localparam int SAIDAS_W = $bits(saidas_t);

    function automatic logic eh_fim(estado_t e);
        return (e == FIM_ACERTOU) || (e == FIM_ERROU) || (e == FIM_TIMEOUT);
    endfunction

endpackage

// File: rtl/controle_jogo_decodificador.sv
// controle_jogo_decodificador: combinational control-word decode for each FSM state
// Ports:
//   estado          in  4   current state code
//   estado_anterior in  4   state held in the previous cycle (tells how preparacao was entered)
//   fim_endereco    in  1   address counter reached round counter
//   saidas          out 11  control word, laid out as saidas_t
module controle_jogo_decodificador
    import jogo_memoria_pkg::*;
(
    input  logic [3:0]          estado,
    input  logic [3:0]          estado_anterior,
    input  logic                fim_endereco,
    output logic [SAIDAS_W-1:0] saidas
);

    saidas_t s;
    estado_t e, a;

    assign e      = estado_t'(estado);
    assign a      = estado_t'(estado_anterior);
    assign saidas = s;

    always_comb begin
        s = '0;
        case (e)
            PREPARACAO: begin
                s.zera_e = 1'b1;
                s.zera_t = 1'b1;
                // round counter restarts only for a new game, not between rounds
                s.zera_r = (a == INICIAL) || eh_fim(a);
            end
            MOSTRA: begin
                s.mostra_leds = 1'b1;
                s.conta_t     = 1'b1;
            end
            PROXIMO_MOSTRA: begin
                // last word shown: leave the address alone, inicia_rodada clears it
                s.conta_e = !fim_endereco;
                s.zera_t  = 1'b1;
            end
            INICIA_RODADA: begin
                s.zera_e = 1'b1;
                s.zera_t = 1'b1;
            end
            ESPERA_JOGADA:  s.conta_t    = 1'b1;
            REGISTRA:       s.registra_r = 1'b1;
            PROXIMA_JOGADA: begin
                s.conta_e = 1'b1;
                s.zera_t  = 1'b1;
            end
            PROXIMA_RODADA: s.conta_r = 1'b1;
            FIM_ACERTOU: begin
                s.pronto = 1'b1;
                s.ganhou = 1'b1;
            end
            FIM_ERROU, FIM_TIMEOUT: begin
                s.pronto = 1'b1;
                s.perdeu = 1'b1;
            end
            default: s = '0;
        endcase
    end

endmodule

// File: rtl/controle_jogo_memoria.sv
// controle_jogo_memoria: Moore control unit for the memory game (show sequence, collect plays, judge)
// Ports:
//   clock, reset                      system clock (rising edge), async active-low reset
//   iniciar                           start/restart request (level)
//   jogada                            one-cycle pulse per button press
//   igual, fim_endereco, fim_rodada   datapath status: play matches, address at round, last round
//   fim_mostra, timeout               shared timer status for display / play phases
//   zera_e/conta_e, zera_r/conta_r    address / round counter control
//   registra_r                        load play register
//   zera_t/conta_t                    shared timer control
//   mostra_leds                       drive LEDs from memory
//   pronto, ganhou, perdeu            game end flags
//   db_estado                         current state code
// All control outputs are registered, so they appear one cycle after the state is entered.
module controle_jogo_memoria
    import jogo_memoria_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       fim_endereco,
    input  logic       fim_rodada,
    input  logic       fim_mostra,
    input  logic       timeout,
    output logic       zera_e,
    output logic       conta_e,
    output logic       zera_r,
    output logic       conta_r,
    output logic       registra_r,
    output logic       zera_t,
    output logic       conta_t,
    output logic       mostra_leds,
    output logic       pronto,
    output logic       ganhou,
    output logic       perdeu,
    output logic [3:0] db_estado
);

    estado_t             estado, proximo, anterior;
    saidas_t             saidas_q;
    logic [SAIDAS_W-1:0] decodificado;

    controle_jogo_decodificador u_decodificador (
        .estado          (estado),
        .estado_anterior (anterior),
        .fim_endereco    (fim_endereco),
        .saidas          (decodificado)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado   <= INICIAL;
            anterior <= INICIAL;
            saidas_q <= '0;
        end else begin
            estado   <= proximo;
            anterior <= estado;
            saidas_q <= saidas_t'(decodificado);
        end
    end

    always_comb begin
        proximo = estado;
        case (estado)
            INICIAL:        proximo = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:     proximo = MOSTRA;
            MOSTRA:         proximo = fim_mostra ? PROXIMO_MOSTRA : MOSTRA;
            PROXIMO_MOSTRA: proximo = fim_endereco ? INICIA_RODADA : MOSTRA;
            INICIA_RODADA:  proximo = ESPERA_JOGADA;
            // a play arriving together with the timeout still counts
            ESPERA_JOGADA:  proximo = jogada ? REGISTRA : timeout ? FIM_TIMEOUT : ESPERA_JOGADA;
            REGISTRA:       proximo = COMPARA;
            COMPARA:        proximo = !igual ? FIM_ERROU :
                                      !fim_endereco ? PROXIMA_JOGADA :
                                      fim_rodada ? FIM_ACERTOU : PROXIMA_RODADA;
            PROXIMA_JOGADA: proximo = ESPERA_JOGADA;
            PROXIMA_RODADA: proximo = PREPARACAO;
            FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT:
                            proximo = iniciar ? PREPARACAO : estado;
            default:        proximo = INICIAL;
        endcase
    end

    assign zera_e      = saidas_q.zera_e;
    assign conta_e     = saidas_q.conta_e;
    assign zera_r      = saidas_q.zera_r;
    assign conta_r     = saidas_q.conta_r;
    assign registra_r  = saidas_q.registra_r;
    assign zera_t      = saidas_q.zera_t;
    assign conta_t     = saidas_q.conta_t;
    assign mostra_leds = saidas_q.mostra_leds;
    assign pronto      = saidas_q.pronto;
    assign ganhou      = saidas_q.ganhou;
    assign perdeu      = saidas_q.perdeu;
    assign db_estado   = estado;

endmodule

// File: doc/controle_jogo_memoria.md
CONTROLE_JOGO_MEMORIA -- requirements
Module: controle_jogo_memoria

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-low reset: reset is asynchronous and active-low.
REQ-002 SHALL expose these ports (name  direction  width  meaning):
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous active-low reset
- iniciar  in  1  start/restart request, level
- jogada  in  1  one-cycle pulse when a button edge is detected
- igual  in  1  registered play equals memory word
- fim_endereco  in  1  address counter equals round counter
- fim_rodada  in  1  round counter at last round (15)
- fim_mostra  in  1  display timer expired
- timeout  in  1  play timer expired
- zera_e, conta_e  out  1  clear / increment the address counter
- zera_r, conta_r  out  1  clear / increment the round counter
- registra_r  out  1  load the play register
- zera_t, conta_t  out  1  clear / enable the timer shared by the display and play phases
- mostra_leds  out  1  drive LEDs from memory output
- pronto, ganhou, perdeu  out  1  game end flags
- db_estado  out  4  current state code

Function
REQ-003 SHALL implement a Moore FSM with these codes: inicial=0, preparacao=1, mostra=2, proximo_mostra=3, inicia_rodada=4, espera_jogada=5, registra=6, compara=7, proxima_jogada=8, proxima_rodada=9, fim_acertou=A, fim_errou=B, fim_timeout=C; unused codes SHALL go to inicial on the next clock.
REQ-004 Transitions:
- inicial -> preparacao when iniciar=1.
- preparacao -> mostra unconditionally.
- mostra -> proximo_mostra when fim_mostra=1.
- proximo_mostra -> inicia_rodada when fim_endereco=1, else -> mostra.
- inicia_rodada -> espera_jogada.
- espera_jogada -> registra on jogada=1; -> fim_timeout on timeout=1; jogada wins if both are asserted.
- registra -> compara.
- compara: igual=0 -> fim_errou; igual=1 with fim_endereco=0 -> proxima_jogada; igual=1 with fim_endereco=1 and fim_rodada=1 -> fim_acertou; otherwise -> proxima_rodada.
- proxima_jogada -> espera_jogada.
- proxima_rodada -> preparacao.
- The three fim states -> preparacao when iniciar=1, else hold.
REQ-005 Output decode (every output not listed is 0):
- preparacao: zera_e=1, zera_t=1; zera_r=1 only when entered from inicial or a fim state.
- mostra: mostra_leds=1, conta_t=1.
- proximo_mostra: conta_e=1, zera_t=1; conta_e SHALL be suppressed when fim_endereco=1.
- inicia_rodada: zera_e=1, zera_t=1.
- espera_jogada: conta_t=1.
- registra: registra_r=1.
- proxima_jogada: conta_e=1, zera_t=1.
- proxima_rodada: conta_r=1.
- fim_acertou: pronto=1, ganhou=1.
- fim_errou and fim_timeout: pronto=1, perdeu=1.
REQ-006 Outputs SHALL be registered (one-cycle latency from state entry); db_estado SHALL equal the current state code.
REQ-007 Round r (0-based) SHALL display r+1 memory words, then accept r+1 plays; after a correct round 15, fim_acertou is reached.
REQ-008 A jogada pulse outside espera_jogada SHALL be ignored.

Reset
REQ-009 While reset=0, the state SHALL be inicial and all outputs 0, independent of clock.
REQ-010 Reset deasserted mid-game SHALL restart at inicial; the game resumes only on iniciar.

Structure
REQ-011 State codes and the round limit (16) SHALL live in shared package jogo_memoria_pkg.
REQ-012 Output decode SHALL be one sub-module, controle_jogo_decodificador, purely combinational from state, feeding the output register.

Verification
REQ-013 Reset pulse low 1 clock -> db_estado=0, all outputs 0; iniciar=1 -> db_estado 1 then 2, zera_r=1 once.
REQ-014 Round 0 with fim_mostra after 2000 clocks and a correct play (igual=1, fim_endereco=1, fim_rodada=0) -> states 5,6,7,9,1; conta_r pulses once.
REQ-015 Wrong play in round 2 (igual=0) -> fim_errou (B), pronto=1, perdeu=1, ganhou=0; iniciar=1 -> preparacao with zera_r=1.
REQ-016 timeout=1 in espera_jogada -> C, perdeu=1; timeout and jogada in the same cycle -> registra (6).
REQ-017 16 correct rounds (fim_rodada=1 at last compara) -> A, ganhou=1, pronto=1, held until iniciar.
REQ-018 reset=0 asserted between clock edges while in espera_jogada -> state 0 immediately; jogada pulses in inicial are ignored.
